sdcard_block_reader: RTL
========================

// Module: sdcard_block_reader
// PURPOSE
// APB3 master sitting directly upstream of the SD card controller's APB slave port.
// On a start pulse it reads a programmed number of 32-bit words from one fixed
// controller register (the data FIFO window) and emits them on a valid/ready stream.
// This frees the CPU from per-word polling during block reads. One outstanding APB
// transfer at a time. Output feeds a memory writer or a checksum stage.
// PARAMETERS
// ADDR_W       5       APB address width; matches the controller's 5-bit PADDR
// DATA_ADDR    5'h0C   byte address of the controller data register read each word
// CNT_W        8       width of the word count (max 2**CNT_W-1 words per job)
// SLOW_CYCLES  1024    ACCESS-phase wait cycles after which slow_flag sets
// PORTS
// clk            in   1        single clock domain
// reset          in   1        asynchronous, active-high
// start          in   1        one-cycle job request; honoured only in IDLE
// word_count     in   CNT_W    words to read; sampled on accepted start
// abort          in   1        terminate the current job early
// busy           out  1        high from accepted start until IDLE re-entered
// done           out  1        one-cycle pulse on job end (normal or abort)
// aborted        out  1        qualifies done: job ended by abort
// slow_flag      out  1        sticky: some ACCESS exceeded SLOW_CYCLES; cleared on start
// words_done     out  CNT_W    words delivered on the stream in the current/last job
// apb_PADDR      out  ADDR_W   constant DATA_ADDR
// apb_PSEL       out  1        APB select
// apb_PENABLE    out  1        APB enable
// apb_PWRITE     out  1        tied 0 (reads only)
// apb_PWDATA     out  32       tied 0
// apb_PREADY     in   1        slave completion
// apb_PRDATA     in   32       slave read data, valid with PREADY
// m_valid        out  1        stream word valid
// m_ready        in   1        stream sink ready
// m_data         out  32       stream word
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, aborted, slow_flag, PSEL, PENABLE, m_valid=0; words_done=0; m_data=0.
// - States: IDLE -> SETUP -> ACCESS -> DRAIN -> (SETUP | IDLE).
// - IDLE: start sets remaining=word_count, clears words_done, slow_flag, aborted.
//   If word_count==0, done pulses next cycle and the block stays IDLE. Otherwise -> SETUP.
// - SETUP (1 cycle): PSEL=1, PENABLE=0 -> ACCESS.
// - ACCESS: PSEL=1, PENABLE=1 until PREADY. On PREADY: m_data<=PRDATA, m_valid<=1,
//   remaining-=1, PSEL/PENABLE drop next cycle -> DRAIN. A wait counter counts ACCESS
//   cycles; reaching SLOW_CYCLES sets slow_flag. The transfer is never abandoned:
//   the APB slave tracks its strobe until PREADY.
// - DRAIN: hold m_data/m_valid until m_ready. On handshake: words_done+=1, then
//   remaining==0 -> IDLE with done pulse; otherwise -> SETUP. Minimum 3 cycles/word.
// - Abort:
//   - In SETUP or DRAIN: go IDLE next cycle; m_valid drops; any undelivered word is discarded.
//   - In ACCESS: latch pending_abort, finish on PREADY, discard PRDATA, then IDLE.
//   - In all cases done=1 and aborted=1 on the exit cycle.
//   - Abort in IDLE is ignored. Abort and start in the same IDLE cycle: start wins.
// - start while busy is ignored (no queueing).
// - m_valid never deasserts without a handshake, except on abort or reset.
// - Async reset mid-transfer forces PSEL=0 immediately. The system resets the slave
//   alongside this block.
// STRUCTURE
// - Shared package sdcard_pkg: state enum (IDLE, SETUP, ACCESS, DRAIN) and APB read
//   address constants for the controller register map.
// - Single module; no sub-module. The output register is a one-entry hold, not a FIFO.
// TESTING
// - count=3, PREADY after 2 wait cycles, m_ready=1 -> 3 SETUP/ACCESS pairs;
//   m_data = slave words in order; done once; words_done=3.
// - count=0 -> no PSEL asserted; done pulses 1 cycle after start; busy stays 0.
// - count=2, m_ready low 10 cycles after first word -> no second SETUP until the
//   handshake; m_data stable throughout.
// - abort while in ACCESS (PREADY 5 cycles later) -> PREADY still awaited; no m_valid;
//   done=aborted=1; words_done unchanged.
// - PREADY held low 1100 cycles -> slow_flag=1, transfer still completes; next start clears slow_flag.
// - reset asserted during ACCESS -> PSEL, PENABLE, m_valid low same cycle; start after
//   deassert runs a clean job.

Source files
------------

// File: rtl/sdcard_pkg.sv
// Shared definitions for the SD card controller: APB register map and block reader states.
package sdcard_pkg;

   localparam int unsigned SdWordW   = 32;
   localparam logic [4:0]  SdRegData = 5'h0C;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StDrain
   } sd_rd_state_e;

endpackage

// File: rtl/sdcard_block_reader.sv
// APB3 master that reads a programmed number of words from the SD controller data
// register and forwards them on a valid/ready stream, one APB transfer at a time.
module sdcard_block_reader
   import sdcard_pkg::*;
#(
   parameter int unsigned      AddrW      = 5,
   parameter logic [AddrW-1:0] DataAddr   = AddrW'(SdRegData),
   parameter int unsigned      CntW       = 8,
   parameter int unsigned      SlowCycles = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [CntW-1:0]    word_count_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               aborted_o,
   output logic               slow_flag_o,
   output logic [CntW-1:0]    words_done_o,
   output logic [AddrW-1:0]   apb_paddr_o,
   output logic               apb_psel_o,
   output logic               apb_penable_o,
   output logic               apb_pwrite_o,
   output logic [SdWordW-1:0] apb_pwdata_o,
   input  logic               apb_pready_i,
   input  logic [SdWordW-1:0] apb_prdata_i,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [SdWordW-1:0] m_data_o
);

   localparam int unsigned WaitW = $clog2(SlowCycles + 1);

   sd_rd_state_e        state_q;
   logic [CntW-1:0]     remaining_q;
   logic [CntW-1:0]     words_done_q;
   logic [WaitW-1:0]    wait_q;
   logic                busy_q, done_q, aborted_q, slow_q, pend_q;
   logic                psel_q, penable_q, m_valid_q;
   logic [SdWordW-1:0]  m_data_q;
   logic                abort_exit;

   // An abort seen during ACCESS only takes effect once the slave completes the transfer.
   always_comb begin
      abort_exit = 1'b0;
      unique case (state_q)
         StIdle:   abort_exit = 1'b0;
         StSetup:  abort_exit = abort_i;
         StAccess: abort_exit = apb_pready_i && (pend_q || abort_i);
         StDrain:  abort_exit = abort_i;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         words_done_q <= '0;
         wait_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         slow_q       <= 1'b0;
         pend_q       <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  remaining_q  <= word_count_i;
                  words_done_q <= '0;
                  slow_q       <= 1'b0;
                  aborted_q    <= 1'b0;
                  pend_q       <= 1'b0;
                  if (word_count_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= StSetup;
                     busy_q  <= 1'b1;
                     psel_q  <= 1'b1;
                  end
               end
            end
            StSetup: begin
               if (!abort_i) begin
                  state_q   <= StAccess;
                  penable_q <= 1'b1;
                  wait_q    <= '0;
               end
            end
            StAccess: begin
               if (wait_q != WaitW'(SlowCycles)) wait_q <= wait_q + WaitW'(1);
               if (wait_q == WaitW'(SlowCycles - 1)) slow_q <= 1'b1;
               if (abort_i) pend_q <= 1'b1;
               if (apb_pready_i) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (!(pend_q || abort_i)) begin
                     m_data_q    <= apb_prdata_i;
                     m_valid_q   <= 1'b1;
                     remaining_q <= remaining_q - CntW'(1);
                     state_q     <= StDrain;
                  end
               end
            end
            StDrain: begin
               // A word taken by the sink counts as delivered even if abort arrives alongside.
               if (m_ready_i) begin
                  words_done_q <= words_done_q + CntW'(1);
                  m_valid_q    <= 1'b0;
                  if (remaining_q == '0) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StSetup;
                     psel_q  <= 1'b1;
                  end
               end
            end
         endcase

         if (abort_exit) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            pend_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            m_valid_q <= 1'b0;
         end
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign aborted_o     = aborted_q;
   assign slow_flag_o   = slow_q;
   assign words_done_o  = words_done_q;
   assign apb_paddr_o   = DataAddr;
   assign apb_psel_o    = psel_q;
   assign apb_penable_o = penable_q;
   assign apb_pwrite_o  = 1'b0;
   assign apb_pwdata_o  = '0;
   assign m_valid_o     = m_valid_q;
   assign m_data_o      = m_data_q;

endmodule
